pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_pkg.sv | 15 +
 rtl/sync_bit.sv | 20 ++
 rtl/pll_reset_sequencer.sv | 101 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and clock-plan constants for the PLL reset sequencer.
package pll_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RUN       = 2'd2,
      LOST      = 2'd3
   } pll_state_e;

   localparam int unsigned SYS_CLK_HZ       = 65536000;
   localparam int unsigned SAMPLE_HZ        = 8000;
   localparam int unsigned TICK_DIV_DEFAULT = SYS_CLK_HZ / SAMPLE_HZ;

endpackage

// File: rtl/sync_bit.sv
// N-stage synchroniser for a single asynchronous bit; flops clear on reset.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sr <= '0;
      else          sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock qualification, system reset release and sample-rate strobe generation.
// Define PLL_RESET_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 65536,
   parameter int unsigned HOLD_CYCLES   = 16,
   parameter int unsigned TICK_DIV      = TICK_DIV_DEFAULT,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             pll_locked,
   output logic             sys_reset_n,
   output logic             ready,
   output logic             sample_tick,
   output logic [CNT_W-1:0] lock_loss_count
);

   localparam int unsigned CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned DW      = $clog2(TICK_DIV);

   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST    = DW'(TICK_DIV - 1);

   logic          locked_s;
   pll_state_e    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [DW-1:0] div, div_nxt;
   logic          run_nxt, tick_nxt;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (pll_locked),
      .q       (locked_s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         WAIT_LOCK: if (locked_s) state_nxt = STABILIZE;
         STABILIZE: begin
            if (!locked_s)               state_nxt = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_nxt = RUN;
            else                         cnt_nxt   = cnt + 1'b1;
         end
         RUN:       if (!locked_s) state_nxt = LOST;
         LOST: begin
            if (cnt == HOLD_LAST) state_nxt = WAIT_LOCK;
            else                  cnt_nxt   = cnt + 1'b1;
         end
         default:   state_nxt = WAIT_LOCK;
      endcase

      // Outputs are registered from the next state so they change on the
      // same edge the FSM does; the divider restarts on every RUN entry.
      run_nxt = (state_nxt == RUN);
      div_nxt = '0;
      if (run_nxt && state == RUN) div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
      tick_nxt = run_nxt && (div_nxt == DIV_LAST);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= WAIT_LOCK;
         cnt         <= '0;
         div         <= '0;
         sys_reset_n <= 1'b0;
         ready       <= 1'b0;
         sample_tick <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         div         <= div_nxt;
         sys_reset_n <= run_nxt;
         ready       <= run_nxt;
         sample_tick <= tick_nxt;
      end
   end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         loss_q <= '0;
      else if (state == RUN && state_nxt == LOST && loss_q != '1)
         loss_q <= loss_q + 1'b1;
   end

   assign lock_loss_count = loss_q;
`else
   assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer using the small test-plan parameters.
module tb_pll_reset_sequencer;

   localparam int unsigned CNT_W = 2;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset_n;
   logic             pll_locked;
   logic             sys_reset_n;
   logic             ready;
   logic             sample_tick;
   logic [CNT_W-1:0] lock_loss_count;

   int tests = 0;
   int fails = 0;

   pll_reset_sequencer #(
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (8),
      .HOLD_CYCLES   (4),
      .TICK_DIV      (5),
      .CNT_W         (CNT_W)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .pll_locked      (pll_locked),
      .sys_reset_n     (sys_reset_n),
      .ready           (ready),
      .sample_tick     (sample_tick),
      .lock_loss_count (lock_loss_count)
   );

   always #5 clock = ~clock;

   // Leaves the DUT out of reset with pll_locked low, just after an edge.
   task automatic apply_reset();
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      #12;
      tests++;
      if ({sys_reset_n, ready, sample_tick, lock_loss_count} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got rst_n=%b rdy=%b tick=%b loss=%0d want all 0",
                  sys_reset_n, ready, sample_tick, lock_loss_count);
      end
   endtask

   // Release expected on edge 11 after pll_locked is first sampled high.
   task automatic test_release();
      apply_reset();
      pll_locked = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         @(posedge clock); #1;
         tests++;
         if (sys_reset_n !== (e >= 11) || ready !== (e >= 11)) begin
            fails++;
            $display("FAIL release edge %0d got rst_n=%b rdy=%b want %b", e, sys_reset_n, ready, e >= 11);
         end
      end
      tests++;
      if (sample_tick !== 1'b0) begin
         fails++;
         $display("FAIL tick_run_cycle0 got %b want 0", sample_tick);
      end
   endtask

   // Continues from RUN cycle 0: ticks in cycles 4 and 9 only.
   task automatic test_tick();
      for (int k = 1; k <= 12; k++) begin
         @(posedge clock); #1;
         tests++;
         if (sample_tick !== (k % 5 == 4)) begin
            fails++;
            $display("FAIL tick cycle %0d got %b want %b", k, sample_tick, k % 5 == 4);
         end
      end
   endtask

   // One-cycle drop during STABILIZE restarts qualification; relock first sampled on edge 7.
   task automatic test_glitch();
      apply_reset();
      pll_locked = 1'b1;
      for (int e = 1; e <= 17; e++) begin
         @(posedge clock); #1;
         if (e == 5) pll_locked = 1'b0;
         if (e == 6) pll_locked = 1'b1;
         tests++;
         if (sys_reset_n !== (e >= 17)) begin
            fails++;
            $display("FAIL glitch edge %0d got rst_n=%b want %b", e, sys_reset_n, e >= 17);
         end
      end
      tests++;
      if (lock_loss_count !== '0) begin
         fails++;
         $display("FAIL glitch_loss_cnt got %0d want 0", lock_loss_count);
      end
   endtask

   // Loss lands on RUN cycle 4, so the suppressed-tick case is covered too.
   task automatic test_lock_loss();
      @(posedge clock); #1;
      pll_locked = 1'b0;
      for (int a = 1; a <= 16; a++) begin
         @(posedge clock); #1;
         if (a == 3) pll_locked = 1'b1;
         tests++;
         if (sys_reset_n !== (a <= 2 || a >= 16) || sample_tick !== 1'b0) begin
            fails++;
            $display("FAIL loss edge %0d got rst_n=%b tick=%b want rst_n=%b tick=0",
                     a, sys_reset_n, sample_tick, a <= 2 || a >= 16);
         end
         if (a == 3) begin
            tests++;
            if (lock_loss_count !== (LOSS_EN ? 2'd1 : 2'd0)) begin
               fails++;
               $display("FAIL loss_cnt_first got %0d want %0d", lock_loss_count, LOSS_EN ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_saturation();
      for (int n = 2; n <= 4; n++) begin
         int waited;
         pll_locked = 1'b0;
         repeat (3) @(posedge clock);
         #1 pll_locked = 1'b1;
         waited = 0;
         while (sys_reset_n !== 1'b1 && waited < 40) begin
            @(posedge clock); #1;
            waited++;
         end
         tests++;
         if (sys_reset_n !== 1'b1) begin
            fails++;
            $display("FAIL sat_relock event %0d got rst_n=%b want 1 within 40 cycles", n, sys_reset_n);
         end
         tests++;
         if (lock_loss_count !== (LOSS_EN ? CNT_W'(n > 3 ? 3 : n) : CNT_W'(0))) begin
            fails++;
            $display("FAIL sat_count event %0d got %0d want %0d", n, lock_loss_count,
                     LOSS_EN ? (n > 3 ? 3 : n) : 0);
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      tests++;
      if ({sys_reset_n, ready, sample_tick, lock_loss_count} !== '0) begin
         fails++;
         $display("FAIL async_reset got rst_n=%b rdy=%b tick=%b loss=%0d want all 0",
                  sys_reset_n, ready, sample_tick, lock_loss_count);
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         @(posedge clock); #1;
         tests++;
         if (sys_reset_n !== (e >= 11)) begin
            fails++;
            $display("FAIL requal edge %0d got rst_n=%b want %b", e, sys_reset_n, e >= 11);
         end
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_tick();
      test_glitch();
      test_lock_loss();
      test_saturation();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
